// File: rtl/load_store_unit.sv
// Load/store unit between the core execute stage and a word-only data memory.
// Optional feature macro: MISALIGN_TRAP_EN (flag and suppress misaligned H/HU/W accesses).
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic              f_b, f_h, f_w, f_bu, f_hu;
    logic              ld_legal, st_legal, ld_req, st_req, idle;
    logic              mis, ld_ok, st_word_ok, st_sub_ok;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        byte_off;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] ld_ext;

    assign f_b  = (funct3_i == 3'b000);
    assign f_h  = (funct3_i == 3'b001);
    assign f_w  = (funct3_i == 3'b010);
    assign f_bu = (funct3_i == 3'b100);
    assign f_hu = (funct3_i == 3'b101);

    assign ld_legal  = f_b | f_h | f_w | f_bu | f_hu;
    assign st_legal  = f_b | f_h | f_w;
    assign ld_req    = req_valid_i & is_load_i;
    assign st_req    = req_valid_i & is_store_i & ~is_load_i;
    assign idle      = (state_q == S_IDLE);
    assign word_addr = {addr_i[ADDR_W-1:2], 2'b00};
    assign byte_off  = addr_i[1:0];

`ifdef MISALIGN_TRAP_EN
    assign mis = idle & ((ld_req & ld_legal) | (st_req & st_legal))
                 & (((f_h | f_hu) & addr_i[0]) | (f_w & (addr_i[1:0] != 2'b00)));
`else
    // Low offending address bits are simply dropped by the lane selects below.
    assign mis = 1'b0;
`endif

    assign ld_ok      = idle & ld_req & ld_legal & ~mis;
    assign st_word_ok = idle & st_req & f_w & ~mis;
    assign st_sub_ok  = idle & st_req & (f_b | f_h) & ~mis;

    always_comb begin
        rd_byte = mem_rdata_i[{byte_off, 3'b000} +: 8];
        rd_half = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        unique case (funct3_i)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_ext = {16'h0, rd_half};
            3'b010:  ld_ext = mem_rdata_i;
            default: ld_ext = '0;
        endcase
    end

    always_comb begin
        merged = mem_rdata_i;
        if (f_b) begin
            merged[{byte_off, 3'b000} +: 8] = store_data_i[7:0];
        end else begin
            merged[{addr_i[1], 4'b0000} +: 16] = store_data_i[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wbuf_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            waddr_q <= waddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wbuf_d  = wbuf_q;
        waddr_d = waddr_q;
        unique case (state_q)
            S_IDLE: begin
                if (st_sub_ok) begin
                    state_d = S_MERGE;
                    wbuf_d  = merged;
                    waddr_d = word_addr;
                end
            end
            S_MERGE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_data_o  = '0;
        stall_o      = 1'b0;
        misaligned_o = mis;
        mem_addr_o   = word_addr;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_wdata_o  = store_data_i;
        unique case (state_q)
            S_IDLE: begin
                if (ld_ok) begin
                    mem_read_o  = 1'b1;
                    load_data_o = ld_ext;
                end
                if (st_word_ok) begin
                    mem_write_o = 1'b1;
                end
                if (st_sub_ok) begin
                    mem_read_o = 1'b1;
                    stall_o    = 1'b1;
                end
            end
            S_MERGE: begin
                // Request held by the stalled core is ignored here.
                mem_write_o = 1'b1;
                mem_addr_o  = waddr_q;
                mem_wdata_o = wbuf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, misaligned;
    logic [31:0] mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .load_data_o  (load_data),
        .stall_o      (stall),
        .misaligned_o (misaligned),
        .mem_addr_o   (mem_addr),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
    endtask

    task automatic idle_req();
        req_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        step();
        pre_we  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        #2;
        check({tag, "_data"}, load_data, exp);
        check({tag, "_rd"}, {31'h0, mem_read}, 32'h1);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        step();
        idle_req();
    endtask

    task automatic sub_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_word);
        preload(6'd16, 32'h11223344);
        drive(1'b0, 1'b1, f3, a, d);
        #2;
        check({tag, "_stall_c1"}, {31'h0, stall}, 32'h1);
        check({tag, "_rd_c1"}, {31'h0, mem_read}, 32'h1);
        check({tag, "_wr_c1"}, {31'h0, mem_write}, 32'h0);
        step();
        #2;
        check({tag, "_stall_c2"}, {31'h0, stall}, 32'h0);
        check({tag, "_wr_c2"}, {31'h0, mem_write}, 32'h1);
        check({tag, "_addr_c2"}, mem_addr, 32'h40);
        check({tag, "_wdata_c2"}, mem_wdata, exp_word);
        step();
        idle_req();
        #2;
        check({tag, "_word"}, mem[16], exp_word);
        check({tag, "_wr_c3"}, {31'h0, mem_write}, 32'h0);
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        pre_we = 1'b0;
        pre_idx = 6'd0;
        pre_val = 32'h0;
        idle_req();
        #3;
        check("rst_load_data", load_data, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_misaligned", {31'h0, misaligned}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // SW: single cycle, no stall
        preload(6'd16, 32'h11223344);
        drive(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        #2;
        check("sw_wr", {31'h0, mem_write}, 32'h1);
        check("sw_stall", {31'h0, stall}, 32'h0);
        check("sw_addr", mem_addr, 32'h40);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        idle_req();
        #2;
        check("sw_wr_after", {31'h0, mem_write}, 32'h0);
        check("sw_word", mem[16], 32'hDEADBEEF);
        step();

        sub_store("sb_42", 3'b000, 32'h42, 32'h000000AB, 32'h11AB3344);
        sub_store("sb_40", 3'b000, 32'h40, 32'hFFFFFF55, 32'h11223355);
        sub_store("sb_43", 3'b000, 32'h43, 32'h000000C3, 32'hC3223344);
        sub_store("sh_42", 3'b001, 32'h42, 32'h0000CAFE, 32'hCAFE3344);
        sub_store("sh_40", 3'b001, 32'h40, 32'h1234BEEF, 32'h1122BEEF);

        preload(6'd17, 32'h00008080);
        do_load("lb_44",  3'b000, 32'h44, 32'hFFFFFF80);
        do_load("lbu_44", 3'b100, 32'h44, 32'h00000080);
        do_load("lh_44",  3'b001, 32'h44, 32'hFFFF8080);
        do_load("lhu_44", 3'b101, 32'h44, 32'h00008080);
        do_load("lw_44",  3'b010, 32'h44, 32'h00008080);
        do_load("lb_45",  3'b000, 32'h45, 32'hFFFFFF80);

        preload(6'd18, 32'h7F01FF00);
        do_load("lb_49",  3'b000, 32'h49, 32'hFFFFFFFF);
        do_load("lbu_4b", 3'b100, 32'h4B, 32'h0000007F);
        do_load("lb_4a",  3'b000, 32'h4A, 32'h00000001);
        do_load("lh_4a",  3'b001, 32'h4A, 32'h00007F01);
        do_load("lhu_48", 3'b101, 32'h48, 32'h0000FF00);

        // Illegal encodings make no access
        drive(1'b1, 1'b0, 3'b011, 32'h44, 32'h0);
        #2;
        check("ill_ld_rd", {31'h0, mem_read}, 32'h0);
        check("ill_ld_data", load_data, 32'h0);
        check("ill_ld_stall", {31'h0, stall}, 32'h0);
        step();
        drive(1'b0, 1'b1, 3'b100, 32'h44, 32'h12345678);
        #2;
        check("ill_st_rd", {31'h0, mem_read}, 32'h0);
        check("ill_st_wr", {31'h0, mem_write}, 32'h0);
        check("ill_st_stall", {31'h0, stall}, 32'h0);
        step();
        drive(1'b0, 1'b0, 3'b010, 32'h44, 32'h12345678);
        #2;
        check("noop_rd", {31'h0, mem_read}, 32'h0);
        check("noop_wr", {31'h0, mem_write}, 32'h0);
        step();
        idle_req();

        // Reset during MERGE drops the pending write
        preload(6'd16, 32'h11223344);
        drive(1'b0, 1'b1, 3'b000, 32'h42, 32'h000000AB);
        step();
        idle_req();
        #1;
        check("mrg_wr_before_rst", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mrg_wr", {31'h0, mem_write}, 32'h0);
        check("rst_mrg_stall", {31'h0, stall}, 32'h0);
        step();
        rst_n = 1'b1;
        #2;
        check("rst_mrg_word", mem[16], 32'h11223344);
        check("rst_mrg_wr_after", {31'h0, mem_write}, 32'h0);
        step();

        // Misaligned word load
        drive(1'b1, 1'b0, 3'b010, 32'h46, 32'h0);
        #2;
`ifdef MISALIGN_TRAP_EN
        check("mis_lw_flag", {31'h0, misaligned}, 32'h1);
        check("mis_lw_rd", {31'h0, mem_read}, 32'h0);
        check("mis_lw_data", load_data, 32'h0);
`else
        check("mis_lw_flag", {31'h0, misaligned}, 32'h0);
        check("mis_lw_rd", {31'h0, mem_read}, 32'h1);
        check("mis_lw_addr", mem_addr, 32'h44);
        check("mis_lw_data", load_data, 32'h00008080);
`endif
        step();
        idle_req();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
